count_expander: RTL and testbench
=================================

# count_expander

- Sequential decoder for the 5:3 counter.
- Accepts one weighted count per handshake on the inputs `cout`, `carry` and `sum`, with weights 4, 2 and 1.
- Replays the count as a fixed-length serial thermometer frame: v ones followed by MAXCNT−v zeros.
- Sits downstream of the compressor array and regenerates canonical bit vectors for the self-checking datapath and for serial links.

## Interface
- MAXCNT, default 5: frame length in beats and the largest legal count. Legal range is 1..7.
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  a count is presented
- in_ready  output  1  block accepts the count this cycle
- cout  input  1  count bit of weight 4
- carry  input  1  count bit of weight 2
- sum  input  1  count bit of weight 1
- out_bit  output  1  current frame bit
- out_valid  output  1  out_bit is valid
- out_ready  input  1  downstream consumes the beat
- out_last  output  1  marks the final beat of the frame (beat MAXCNT−1)
- err  output  1  one-cycle pulse: the accepted count exceeded MAXCNT
- thermo  output  MAXCNT  parallel thermometer word; present only with COUNT_EXPANDER_THERMO_EN

## Operation
- Count value: v = 4·cout + 2·carry + sum, a 3-bit unsigned value.
- Acceptance: in_valid & in_ready.
- Over-range input (v > MAXCNT): the count is clamped to MAXCNT and err pulses.
- State machine:
  - IDLE → SHIFT on acceptance.
  - In SHIFT, each beat handshake (out_valid & out_ready) advances the beat index idx from 0 to MAXCNT−1.
  - A handshake on the last beat with no new acceptance → IDLE.
  - A handshake on the last beat together with an acceptance → stays in SHIFT, idx = 0, new count loaded.
- Beat output: out_bit = (idx < v_latched), out_last = (idx == MAXCNT−1).
- Zero count: v = 0 still produces a full frame of MAXCNT zeros.
- Output register values when out_valid = 0: out_bit = 0, out_last = 0.
- Readiness: in_ready = (state == IDLE) | (state == SHIFT & out_last & out_ready). This is combinational from out_ready.
- Backpressure: while out_valid & !out_ready, out_bit, out_last and idx hold.
- The count inputs (cout, carry, sum) are sampled only at acceptance.
- Reset values: state IDLE, idx 0, v_latched 0, out_valid 0, out_bit 0, out_last 0, err 0, thermo 0. in_ready reads 1 after reset.
- Reset mid-frame: the frame is discarded immediately; no partial-frame recovery.

## Timing
- Acceptance at edge N → first beat visible after edge N, with out_valid = 1 in cycle N+1.
- With out_ready held high, the frame occupies cycles N+1..N+MAXCNT, with out_last in cycle N+MAXCNT.
- Back-to-back frames: a count accepted in the same cycle as the last-beat handshake starts its frame the next cycle with no bubble. Sustained throughput is one count per MAXCNT cycles.
- err is registered: high for exactly cycle N+1 after an over-range acceptance.
- Reset is asynchronous: asserting rst forces every output to its reset value without waiting for a clock edge. Deassertion is synchronous to clk by the integrator.

## Configuration
- COUNT_EXPANDER_THERMO_EN defined:
  - The thermo port exists.
  - At each acceptance thermo is loaded with (1<<v_clamped)−1, updated in cycle N+1 together with the first beat.
  - thermo holds until the next acceptance; reset value 0.
- Undefined: the thermo port and its register are absent. All serial behaviour is identical.

## Test plan
- Reset check: assert rst mid-simulation, no clock → out_valid = 0, out_bit = 0, err = 0, thermo = 0 immediately; in_ready = 1 after release.
- Basic frame: v = 3 (cout 0, carry 1, sum 1), out_ready = 1, accepted at cycle N → out_bit 1,1,1,0,0 in cycles N+1..N+5, out_last only at N+5, err stays 0, thermo = 5'b00111.
- Back-to-back: v = 5 then v = 0, in_valid held → 1,1,1,1,1 then 0,0,0,0,0 with no idle cycle; in_ready high only in IDLE and on the last beat.
- Backpressure: v = 2, out_ready low for 3 cycles at beat 1 → out_bit = 1 and idx held for those cycles, then beats continue 1,0,0,0; frame still totals 5 beats.
- Over-range: v = 7 → err high for exactly one cycle (N+1), frame 1,1,1,1,1, thermo = 5'b11111.
- Reset mid-frame: rst asserted during beat 2 of a v = 4 frame → out_valid = 0 at once; after release the next count (v = 1) produces a clean frame 1,0,0,0,0.

Source files
------------

// File: rtl/count_expander.sv
// count_expander
//
// Sequential decoder for the 5:3 counter. Takes one weighted count
// (cout*4 + carry*2 + sum) per input handshake and replays it as a
// fixed-length serial thermometer frame of MAXCNT beats: v ones followed
// by MAXCNT-v zeros. Counts above MAXCNT are clamped and flagged on err.
//
// Parameters:
//   MAXCNT     frame length in beats and largest legal count (1..7)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous reset, active-high
//   in_valid   a count is presented
//   in_ready   count is accepted this cycle (combinational from out_ready)
//   cout       count bit of weight 4
//   carry      count bit of weight 2
//   sum        count bit of weight 1
//   out_bit    current frame bit
//   out_valid  out_bit is valid
//   out_ready  downstream consumes the beat
//   out_last   final beat of the frame
//   err        one-cycle pulse after an over-range count was accepted
//   thermo     parallel thermometer word of the last accepted count
//              (only when COUNT_EXPANDER_THERMO_EN is defined)
//
// Optional feature macro: COUNT_EXPANDER_THERMO_EN

module count_expander #(
    parameter int MAXCNT = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              cout,
    input  logic              carry,
    input  logic              sum,
    output logic              out_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              err
`ifdef COUNT_EXPANDER_THERMO_EN
    ,
    output logic [MAXCNT-1:0] thermo
`endif
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [2:0] MAX_V    = 3'(MAXCNT);
    localparam logic [2:0] LAST_IDX = 3'(MAXCNT - 1);

    state_t     state, state_next;
    logic [2:0] idx, idx_next, idx_inc;
    logic [2:0] v_lat, v_lat_next;
    logic [2:0] v_in, v_clamped;
    logic       over_range, accept, beat_done;
    logic       out_valid_next, out_bit_next, out_last_next, err_next;

    // Decode the weighted count and clamp anything beyond the frame length
    assign v_in       = {cout, carry, sum};
    assign over_range = (v_in > MAX_V);
    assign v_clamped  = over_range ? MAX_V : v_in;
    assign idx_inc    = idx + 3'd1;
    assign beat_done  = out_valid & out_ready;

    // A new count may enter while idle, or in the very cycle the last beat
    // is consumed so consecutive frames run without a bubble
    assign in_ready = (state == IDLE) | ((state == SHIFT) & out_last & out_ready);
    assign accept   = in_valid & in_ready;

    // Next-state and next-output logic. The beat outputs are registered, so
    // each branch computes the bit/last flags for the beat that becomes
    // visible after the coming edge. An acceptance takes priority because it
    // can coincide with the last-beat handshake.
    always_comb begin
        state_next     = state;
        idx_next       = idx;
        v_lat_next     = v_lat;
        out_valid_next = out_valid;
        out_bit_next   = out_bit;
        out_last_next  = out_last;
        err_next       = 1'b0;

        if (accept) begin
            state_next     = SHIFT;
            idx_next       = 3'd0;
            v_lat_next     = v_clamped;
            out_valid_next = 1'b1;
            out_bit_next   = (v_clamped != 3'd0);
            out_last_next  = (LAST_IDX == 3'd0);
            err_next       = over_range;
        end else begin
            case (state)
                SHIFT: begin
                    if (beat_done) begin
                        if (out_last) begin
                            state_next     = IDLE;
                            idx_next       = 3'd0;
                            out_valid_next = 1'b0;
                            out_bit_next   = 1'b0;
                            out_last_next  = 1'b0;
                        end else begin
                            idx_next      = idx_inc;
                            out_bit_next  = (idx_inc < v_lat);
                            out_last_next = (idx_inc == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset discards any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 3'd0;
            v_lat     <= 3'd0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            v_lat     <= v_lat_next;
            out_valid <= out_valid_next;
            out_bit   <= out_bit_next;
            out_last  <= out_last_next;
            err       <= err_next;
        end
    end

`ifdef COUNT_EXPANDER_THERMO_EN
    logic [MAXCNT-1:0] thermo_next;

    // Parallel thermometer word (1<<v)-1 of the clamped count, loaded at
    // acceptance so it appears together with the first serial beat
    always_comb begin
        thermo_next = thermo;
        if (accept) begin
            for (int i = 0; i < MAXCNT; i++) begin
                thermo_next[i] = (3'(i) < v_clamped);
            end
        end
    end

    // Thermometer register holds until the next acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thermo <= '0;
        end else begin
            thermo <= thermo_next;
        end
    end
`endif

endmodule

// File: tb/tb_count_expander.sv
// tb_count_expander
//
// Self-checking bench for count_expander (MAXCNT = 5). Every accepted count
// pushes its expected frame beats onto a scoreboard queue; each cycle the
// visible beat is compared against the queue head and popped on a handshake.
// in_ready, out_valid, err and (when COUNT_EXPANDER_THERMO_EN is defined)
// thermo are compared every cycle against the bench's own expectations.

module tb_count_expander;

    localparam int MAXCNT = 5;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_ready;
    logic cout;
    logic carry;
    logic sum;
    logic out_bit;
    logic out_valid;
    logic out_ready;
    logic out_last;
    logic err;
`ifdef COUNT_EXPANDER_THERMO_EN
    logic [MAXCNT-1:0] thermo;
`endif

    count_expander #(.MAXCNT(MAXCNT)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cout     (cout),
        .carry    (carry),
        .sum      (sum),
        .out_bit  (out_bit),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .err      (err)
`ifdef COUNT_EXPANDER_THERMO_EN
        ,
        .thermo   (thermo)
`endif
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    typedef struct {
        logic b;
        logic last;
    } beat_t;

    typedef struct {
        logic [2:0]        v;
        logic [MAXCNT-1:0] frame;
        logic              errExp;
    } vec_t;

    beat_t             sb[$];
    vec_t              vecs[8];
    int                nVec = 0;
    int                nMis = 0;
    logic              errExp;
    logic [MAXCNT-1:0] thermoExp;

    // Single comparison: bumps the vector count, reports and counts a miss
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs against the scoreboard/model; pop on handshake
    task automatic checkOutput(input logic ordy, output logic readyExp);
        logic validExp;
        validExp = (sb.size() != 0);
        if (!validExp) readyExp = 1'b1;
        else readyExp = sb[0].last && ordy;
        chk("in_ready", in_ready, readyExp);
        chk("out_valid", out_valid, validExp);
        if (validExp) begin
            chk("out_bit", out_bit, sb[0].b);
            chk("out_last", out_last, sb[0].last);
            if (ordy) void'(sb.pop_front());
        end else begin
            chk("out_bit_idle", out_bit, 1'b0);
            chk("out_last_idle", out_last, 1'b0);
        end
        chk("err", err, errExp);
`ifdef COUNT_EXPANDER_THERMO_EN
        chk("thermo", thermo, thermoExp);
`endif
    endtask

    // One clock cycle: drive inputs after the falling edge, check, and
    // record what the next rising edge should do
    task automatic applyStimulus(input logic iv, input logic [2:0] v, input logic ordy,
                                 input logic [MAXCNT-1:0] frame, input logic errIfAcc,
                                 output logic acc);
        logic rdy;
        @(negedge clk);
        in_valid  = iv;
        {cout, carry, sum} = v;
        out_ready = ordy;
        #1;
        checkOutput(ordy, rdy);
        acc    = iv && rdy;
        errExp = acc && errIfAcc;
        if (acc) begin
            for (int i = 0; i < MAXCNT; i++) begin
                sb.push_back('{b: frame[i], last: (i == MAXCNT - 1)});
            end
            thermoExp = frame;
        end
    endtask

    // Offer a count until accepted, bounded by a cycle budget
    task automatic sendCount(input logic [2:0] v, input logic [MAXCNT-1:0] frame, input logic e);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 2 * MAXCNT + 2) begin
            applyStimulus(1'b1, v, 1'b1, frame, e, acc);
            tries++;
        end
        chk("accepted", acc, 1'b1);
    endtask

    task automatic drain(input int n);
        logic acc;
        repeat (n) applyStimulus(1'b0, 3'd0, 1'b1, '0, 1'b0, acc);
    endtask

    // Assert reset between clock edges and check outputs clear at once
    task automatic doReset();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_bit", out_bit, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_err", err, 1'b0);
`ifdef COUNT_EXPANDER_THERMO_EN
        chk("rst_thermo", thermo, '0);
`endif
        sb.delete();
        errExp    = 1'b0;
        thermoExp = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        logic acc;
        int   waited;

        rst       = 1'b0;
        in_valid  = 1'b0;
        cout      = 1'b0;
        carry     = 1'b0;
        sum       = 1'b0;
        out_ready = 1'b0;
        errExp    = 1'b0;
        thermoExp = '0;

        doReset();

        // Count table: frame bit i is beat i
        vecs[0] = '{3'd0, 5'b00000, 1'b0};
        vecs[1] = '{3'd1, 5'b00001, 1'b0};
        vecs[2] = '{3'd2, 5'b00011, 1'b0};
        vecs[3] = '{3'd3, 5'b00111, 1'b0};
        vecs[4] = '{3'd4, 5'b01111, 1'b0};
        vecs[5] = '{3'd5, 5'b11111, 1'b0};
        vecs[6] = '{3'd6, 5'b11111, 1'b1};
        vecs[7] = '{3'd7, 5'b11111, 1'b1};

        for (int k = 0; k < 8; k++) begin
            sendCount(vecs[k].v, vecs[k].frame, vecs[k].errExp);
            drain(MAXCNT + 1);
        end

        // Back-to-back: v=5 then v=0 with in_valid held
        sendCount(3'd5, 5'b11111, 1'b0);
        waited = 0;
        acc    = 1'b0;
        while (!acc && waited < 2 * MAXCNT) begin
            applyStimulus(1'b1, 3'd0, 1'b1, 5'b00000, 1'b0, acc);
            waited++;
        end
        chk("b2b_accept_cycle", waited, MAXCNT);
        drain(MAXCNT + 1);

        // Backpressure: v=2, stall three cycles on beat 1
        sendCount(3'd2, 5'b00011, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b1, '0, 1'b0, acc);
        repeat (3) applyStimulus(1'b0, 3'd0, 1'b0, '0, 1'b0, acc);
        repeat (4) applyStimulus(1'b0, 3'd0, 1'b1, '0, 1'b0, acc);
        chk("bp_frame_done", sb.size(), 0);
        drain(1);

        // Reset during beat 2 of a v=4 frame, then a clean v=1 frame
        sendCount(3'd4, 5'b01111, 1'b0);
        repeat (2) applyStimulus(1'b0, 3'd0, 1'b1, '0, 1'b0, acc);
        @(posedge clk);
        #1;
        chk("pre_reset_valid", out_valid, 1'b1);
        doReset();
        sendCount(3'd1, 5'b00001, 1'b0);
        drain(MAXCNT + 1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
